// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset vector, fetch FSM
// encoding, the nop word and the MIPS rs/rt field positions.
package if_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      SKID = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   function automatic logic [4:0] rs_field(input logic [31:0] inst);
      return inst[RS_MSB:RS_LSB];
   endfunction

   function automatic logic [4:0] rt_field(input logic [31:0] inst);
      return inst[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus seen by the fetch stage.
interface if_fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/if_fetch_stage_hazard_lu.sv
// Load-use hazard detector: compares the ID/EX load destination against the
// source fields of the instruction sitting in IF/ID.
module hazard_lu
   import if_fetch_stage_pkg::*;
(
   input  logic       ifid_valid,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   input  logic       redirect,
   output logic       lu,
   output logic       idex_flush
);

   logic rt_nonzero;
   logic src_match;

   // $0 is hardwired, so a load targeting it never creates a dependency
   assign rt_nonzero = (idex_rt != 5'd0);
   assign src_match  = (idex_rt == ifid_rs) | (idex_rt == ifid_rt);
   assign lu         = ifid_valid & idex_memread & rt_nonzero & src_match;
   assign idex_flush = lu | redirect;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: pc, IF/ID register and a three-state fetch FSM
// that buffers one word under stall and discards responses after a redirect.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   if_fetch_stage_if.master  imem,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              idex_memread,
   input  logic [4:0]        idex_rt,
   input  logic              hold,
   output logic              ifid_valid,
   output logic [31:0]       ifid_inst,
   output logic [31:0]       ifid_pc4,
   output logic              idex_flush
);

   fetch_state_e state, state_next;

   logic [31:0] pc, pc_next, pc_plus4;
   logic        ifid_valid_next;
   logic [31:0] ifid_inst_next, ifid_pc4_next;
   logic [31:0] skid, skid_next;
   logic [31:0] skid_pc4, skid_pc4_next;
   logic [31:0] drop_addr, drop_addr_next;
   logic        imem_req_c;
   logic [31:0] imem_addr_c;
   logic        lu;
   logic        stall_f;

   hazard_lu u_hazard_lu (
      .ifid_valid   (ifid_valid),
      .ifid_rs      (rs_field(ifid_inst)),
      .ifid_rt      (rt_field(ifid_inst)),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .redirect     (redirect),
      .lu           (lu),
      .idex_flush   (idex_flush)
   );

   assign stall_f  = (lu | hold) & ~redirect;
   assign pc_plus4 = pc + 32'd4;

   // Request is masked while reset is asserted so nothing is issued until release
   assign imem.imem_req  = rst_n & imem_req_c;
   assign imem.imem_addr = imem_addr_c;

   always_comb begin
      state_next      = state;
      pc_next         = pc;
      ifid_valid_next = ifid_valid;
      ifid_inst_next  = ifid_inst;
      ifid_pc4_next   = ifid_pc4;
      skid_next       = skid;
      skid_pc4_next   = skid_pc4;
      drop_addr_next  = drop_addr;
      imem_req_c      = 1'b0;
      imem_addr_c     = pc;

      unique case (state)
         REQ: begin
            imem_req_c  = 1'b1;
            imem_addr_c = pc;
            if (redirect) begin
               // The outstanding address must stay on the bus until it is accepted
               if (!imem.imem_ready) begin
                  drop_addr_next = pc;
                  state_next     = DROP;
               end
            end else if (imem.imem_ready) begin
               pc_next = pc_plus4;
               if (stall_f) begin
                  skid_next     = imem.imem_rdata;
                  skid_pc4_next = pc_plus4;
                  state_next    = SKID;
               end else begin
                  ifid_valid_next = 1'b1;
                  ifid_inst_next  = imem.imem_rdata;
                  ifid_pc4_next   = pc_plus4;
               end
            end
         end
         SKID: begin
            if (redirect) begin
               state_next = REQ;
            end else if (!stall_f) begin
               ifid_valid_next = 1'b1;
               ifid_inst_next  = skid;
               ifid_pc4_next   = skid_pc4;
               state_next      = REQ;
            end
         end
         DROP: begin
            imem_req_c  = 1'b1;
            imem_addr_c = drop_addr;
            if (imem.imem_ready) begin
               state_next = REQ;
            end
         end
         default: begin
            state_next = REQ;
         end
      endcase

      // A taken branch overrides everything fetched on the wrong path
      if (redirect) begin
         pc_next         = redirect_pc;
         ifid_valid_next = 1'b0;
         ifid_inst_next  = NOP;
         ifid_pc4_next   = 32'd0;
         skid_next       = NOP;
         skid_pc4_next   = 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= REQ;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         ifid_valid <= 1'b0;
         ifid_inst  <= NOP;
         ifid_pc4   <= 32'd0;
         skid       <= NOP;
         skid_pc4   <= 32'd0;
         drop_addr  <= 32'd0;
      end else begin
         pc         <= pc_next;
         ifid_valid <= ifid_valid_next;
         ifid_inst  <= ifid_inst_next;
         ifid_pc4   <= ifid_pc4_next;
         skid       <= skid_next;
         skid_pc4   <= skid_pc4_next;
         drop_addr  <= drop_addr_next;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic checked
// against a queue-based fetch model.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        idex_memread;
   logic [4:0]  idex_rt;
   logic        hold;
   logic        ifid_valid;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc4;
   logic        idex_flush;

   int checks;
   int errors;

   if_fetch_stage_if imem_bus ();

   if_fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (imem_bus),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .hold         (hold),
      .ifid_valid   (ifid_valid),
      .ifid_inst    (ifid_inst),
      .ifid_pc4     (ifid_pc4),
      .idex_flush   (idex_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: IF/ID slot, one-entry word buffer, pending-discard address
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   logic [63:0] m_buf[$];
   logic        m_drop;
   logic [31:0] m_drop_addr;

   localparam logic [31:0] ADD_9_8_10 = 32'h010A_4820;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0000_3000;
      m_valid = 1'b0;
      m_inst  = 32'd0;
      m_pc4   = 32'd0;
      m_buf.delete();
      m_drop      = 1'b0;
      m_drop_addr = 32'd0;
   endtask

   function automatic logic model_lu();
      logic [4:0] rs;
      logic [4:0] rt;
      rs = m_inst[25:21];
      rt = m_inst[20:16];
      return m_valid && idex_memread && (idex_rt != 5'd0) && (idex_rt == rs || idex_rt == rt);
   endfunction

   task automatic compare_all();
      logic        exp_req;
      logic [31:0] exp_addr;
      exp_req  = (m_buf.size() == 0);
      exp_addr = m_drop ? m_drop_addr : m_pc;
      check_output("flush", {31'd0, idex_flush}, {31'd0, model_lu() | redirect});
      check_output("req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
      if (exp_req) check_output("addr", imem_bus.imem_addr, exp_addr);
      check_output("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check_output("inst", ifid_inst, m_inst);
      check_output("pc4", ifid_pc4, m_pc4);
   endtask

   task automatic model_step();
      logic        stall;
      logic        rdy;
      logic [63:0] word;
      stall = (model_lu() || hold) && !redirect;
      rdy   = imem_bus.imem_ready;
      if (redirect) begin
         if (m_buf.size() != 0) begin
            m_buf.delete();
         end else if (m_drop) begin
            if (rdy) m_drop = 1'b0;
         end else if (!rdy) begin
            m_drop      = 1'b1;
            m_drop_addr = m_pc;
         end
         m_pc    = redirect_pc;
         m_valid = 1'b0;
         m_inst  = 32'd0;
         m_pc4   = 32'd0;
      end else if (m_drop) begin
         if (rdy) m_drop = 1'b0;
      end else if (m_buf.size() != 0) begin
         if (!stall) begin
            word    = m_buf.pop_front();
            m_valid = 1'b1;
            m_inst  = word[63:32];
            m_pc4   = word[31:0];
         end
      end else if (rdy) begin
         word = {imem_bus.imem_rdata, m_pc + 32'd4};
         m_pc = m_pc + 32'd4;
         if (stall) begin
            m_buf.push_back(word);
         end else begin
            m_valid = 1'b1;
            m_inst  = word[63:32];
            m_pc4   = word[31:0];
         end
      end
   endtask

   task automatic apply_stimulus(input logic rdy, input logic [31:0] rdata, input logic rdr,
                                 input logic [31:0] rpc, input logic mr, input logic [4:0] rt,
                                 input logic hld);
      @(negedge clk);
      imem_bus.imem_ready = rdy;
      imem_bus.imem_rdata = rdata;
      redirect     = rdr;
      redirect_pc  = rpc;
      idex_memread = mr;
      idex_rt      = rt;
      hold         = hld;
      #1;
      compare_all();
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'd0;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      idex_memread = 1'b0;
      idex_rt      = 5'd0;
      hold         = 1'b0;
      #1;
      check_output("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check_output("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check_output("rst_inst", ifid_inst, 32'd0);
      check_output("rst_pc4", ifid_pc4, 32'd0);
      check_output("rst_addr", imem_bus.imem_addr, 32'h0000_3000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check_output("first_addr", imem_bus.imem_addr, 32'h0000_3000);
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] rdata;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'd0;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      idex_memread = 1'b0;
      idex_rt      = 5'd0;
      hold         = 1'b0;
      model_reset();

      // Streaming at one word per cycle
      do_reset();
      apply_stimulus(1'b1, 32'h1111_0001, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("s_addr0", imem_bus.imem_addr, 32'h0000_3000);
      apply_stimulus(1'b1, 32'h1111_0002, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("s_addr1", imem_bus.imem_addr, 32'h0000_3004);
      check_output("s_pc4_0", ifid_pc4, 32'h0000_3004);
      check_output("s_inst0", ifid_inst, 32'h1111_0001);
      apply_stimulus(1'b1, 32'h1111_0003, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("s_addr2", imem_bus.imem_addr, 32'h0000_3008);
      check_output("s_pc4_1", ifid_pc4, 32'h0000_3008);

      // Load-use: lw $8 in ID/EX against add $9,$8,$10 in IF/ID
      do_reset();
      apply_stimulus(1'b1, ADD_9_8_10, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      apply_stimulus(1'b1, 32'h2000_0001, 1'b0, 32'd0, 1'b1, 5'd8, 1'b0);
      check_output("lu_flush", {31'd0, idex_flush}, 32'd1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("lu_req_skid", {31'd0, imem_bus.imem_req}, 32'd0);
      check_output("lu_flush_off", {31'd0, idex_flush}, 32'd0);
      check_output("lu_inst_held", ifid_inst, ADD_9_8_10);
      check_output("lu_pc4_held", ifid_pc4, 32'h0000_3004);
      apply_stimulus(1'b1, 32'h2000_0002, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("lu_skid_inst", ifid_inst, 32'h2000_0001);
      check_output("lu_skid_pc4", ifid_pc4, 32'h0000_3008);
      check_output("lu_next_addr", imem_bus.imem_addr, 32'h0000_3008);

      // Redirect while the fetch is still pending
      do_reset();
      apply_stimulus(1'b0, 32'd0, 1'b1, 32'h0000_4000, 1'b0, 5'd0, 1'b0);
      check_output("rd_flush", {31'd0, idex_flush}, 32'd1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("rd_old_addr", imem_bus.imem_addr, 32'h0000_3000);
      check_output("rd_cleared", {31'd0, ifid_valid}, 32'd0);
      apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("rd_old_addr2", imem_bus.imem_addr, 32'h0000_3000);
      apply_stimulus(1'b1, 32'h0000_0044, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("rd_new_addr", imem_bus.imem_addr, 32'h0000_4000);
      check_output("rd_discarded", ifid_inst, 32'd0);
      apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("rd_inst", ifid_inst, 32'h0000_0044);
      check_output("rd_pc4", ifid_pc4, 32'h0000_4004);

      // Redirect and hold together
      apply_stimulus(1'b1, 32'h0000_0055, 1'b1, 32'h0000_5000, 1'b0, 5'd0, 1'b1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("rh_valid", {31'd0, ifid_valid}, 32'd0);
      check_output("rh_inst", ifid_inst, 32'd0);
      check_output("rh_addr", imem_bus.imem_addr, 32'h0000_5000);

      // Reset while a word sits in the skid buffer
      apply_stimulus(1'b1, 32'h0000_0066, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      check_output("mr_in_skid", {31'd0, imem_bus.imem_req}, 32'd0);
      do_reset();

      // pc wrap-around
      apply_stimulus(1'b1, 32'h0000_0070, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0);
      apply_stimulus(1'b1, 32'h0000_0077, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
      apply_stimulus(1'b1, 32'h0000_0078, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      check_output("wr_pc4", ifid_pc4, 32'd0);
      check_output("wr_next_addr", imem_bus.imem_addr, 32'd0);

      // Hold with no incoming data keeps IF/ID frozen
      repeat (6) apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      check_output("hold_inst", ifid_inst, 32'h0000_0078);
      check_output("hold_pc4", ifid_pc4, 32'h0000_0004);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset();
         rpc = $urandom;
         rpc[1:0] = 2'b00;
         if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF8;
         rdata = $urandom;
         rdata[31:26] = 6'd0;
         rdata[25:21] = 5'($urandom_range(3));
         rdata[20:16] = 5'($urandom_range(3));
         apply_stimulus(($urandom_range(3) != 0), rdata, ($urandom_range(15) == 0), rpc,
                        ($urandom_range(2) == 0), 5'($urandom_range(3)),
                        ($urandom_range(7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: fetch byte address, held stable until imem_ready.
REQ-006 The block SHALL have port imem_ready, input, 1 bit: request accepted, with data valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: the fetched instruction.
REQ-008 The block SHALL have port redirect, input, 1 bit: branch or jump taken, resolved in EX.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-010 The block SHALL have port idex_memread, input, 1 bit: the ID/EX-stage instruction is a load.
REQ-011 The block SHALL have port idex_rt, input, 5 bits: the load destination register.
REQ-012 The block SHALL have port hold, input, 1 bit: downstream back-pressure, such as multi-cycle EX.
REQ-013 The block SHALL have port ifid_valid, output, 1 bit: the IF/ID slot holds a real instruction.
REQ-014 The block SHALL have port ifid_inst, output, 32 bits: the IF/ID instruction; 0 (nop) when not valid.
REQ-015 The block SHALL have port ifid_pc4, output, 32 bits: fetch address + 4 of ifid_inst.
REQ-016 The block SHALL have port idex_flush, output, 1 bit: bubble request to the ID/EX register.

Function
REQ-017 The load-use hazard lu SHALL be ifid_valid & idex_memread & (idex_rt!=0) & (idex_rt==ifid_inst[25:21] | idex_rt==ifid_inst[20:16]), purely combinational.
REQ-018 idex_flush SHALL be lu | redirect, combinational, with no register delay.
REQ-019 The stall condition stall_f SHALL be (lu | hold) & !redirect; while stall_f is high, IF/ID and pc SHALL hold.
REQ-020 The FSM SHALL have three states:
- REQ: imem_req=1, imem_addr=pc.
- SKID: imem_req=0; one fetched word is buffered.
- DROP: imem_req=1, imem_addr=drop_addr; the response is discarded.
REQ-021 REQ transitions SHALL be:
- imem_ready & !stall_f & !redirect: IF/ID <= {1, imem_rdata, pc+4}; pc <= pc+4; stay in REQ.
- imem_ready & stall_f: skid <= imem_rdata; pc <= pc+4; go to SKID.
REQ-022 SKID transition: when !stall_f & !redirect, IF/ID <= {1, skid, skid_pc4} and the block returns to REQ; otherwise it stays in SKID.
REQ-023 A redirect in any state SHALL, in the same edge:
- load pc <= redirect_pc;
- clear IF/ID (valid 0, inst 0, pc4 0);
- discard the skid buffer.
REQ-024 Redirect in REQ with !imem_ready SHALL latch drop_addr <= pc and go to DROP, keeping imem_addr stable.
REQ-025 Redirect in REQ with imem_ready SHALL discard imem_rdata and stay in REQ, fetching redirect_pc the next cycle.
REQ-026 Redirect in SKID SHALL go to REQ.
REQ-027 DROP transition: on imem_ready the response is discarded and the block goes to REQ; a further redirect while in DROP updates pc only.
REQ-028 With hold=1 and no incoming data, IF/ID contents SHALL remain unchanged indefinitely.
REQ-029 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 without error.
REQ-030 Fetch throughput SHALL be one instruction per cycle when imem_ready=1 continuously and there is no stall.

Reset
REQ-031 While rst_n=0, the block SHALL hold:
- pc=RESET_PC, state=REQ, imem_req=0;
- ifid_valid=0, ifid_inst=0, ifid_pc4=0;
- skid and drop_addr = 0.
REQ-032 The first request SHALL be issued in the first cycle after rst_n deasserts; an in-flight request cut off by reset is abandoned and its late imem_ready is ignored.

Structure
REQ-033 The shared pipeline package SHALL hold RESET_PC, the FSM state encoding (REQ, SKID, DROP), the NOP constant 32'h0 and the rs/rt field bit positions.
REQ-034 Hazard detection SHALL be one sub-module, hazard_lu (combinational: lu, idex_flush); the FSM, pc and IF/ID registers live in the top.

Verification
REQ-035 Directed scenario, streaming: reset, imem_ready=1 constantly -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; ifid_pc4 0x3004 one cycle after the first.
REQ-036 Directed scenario, load-use: ID/EX holds lw into $8, ifid_inst=add $9,$8,$10 -> idex_flush=1 for one cycle, IF/ID and pc held, the fetched word buffered in SKID and delivered the next cycle.
REQ-037 Directed scenario, redirect with pending fetch: imem_ready=0, redirect=1 to 0x4000 -> IF/ID cleared; imem_addr stays at the old pc until ready; the word is discarded; the next request is at 0x4000.
REQ-038 Directed scenario, redirect versus hold: redirect and hold asserted in the same cycle -> redirect wins; IF/ID cleared, pc=redirect_pc.
REQ-039 Directed scenario, mid-operation reset: rst_n pulsed low while in SKID -> all outputs return to reset values immediately; the first request is at 0x3000.
REQ-040 Directed scenario, wrap: pc=0xFFFF_FFFC fetched -> ifid_pc4=0, next imem_addr=0.
